ca_trip_annunciator: RTL

- Downstream consumer of the CA protection card outputs (status alarm, CA-not-OK, I_CA high, U_CA low).
- Filters each fault, latches it, and records the first-out fault.
- Drives the CA trip, horn and per-fault lamps through an acknowledge/reset alarm sequence (flash on new fault, steady once acknowledged).
- Counts trips for the operator panel.

---
 rtl/ca_trip_annunciator.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ca_trip_annunciator.sv
`default_nettype none
// ============================================================================
// ca_trip_annunciator : qualifies CA protection faults, records the first-out
// fault and sequences trip / horn / lamps through acknowledge and reset.
// Rev 1.0
// ============================================================================
module ca_trip_annunciator #(
  parameter int QUAL       = 4,
  parameter int BLINK_HALF = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_not_alarm,
  input  logic       i_not_ca_ok,
  input  logic       i_ca_delay,
  input  logic       i_i_ca_high_n,
  input  logic       i_u_ca_low_n,
  input  logic       i_ack,
  input  logic       i_rst,
  output logic       o_trip,
  output logic       o_horn,
  output logic [3:0] o_lamp,
  output logic [1:0] o_first_out,
  output logic       o_first_valid,
  output logic [7:0] o_trip_count
);
  localparam int            BW         = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [3:0]    QUAL_C     = 4'(QUAL);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    TRIP   = 2'd1,
    ACKED  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    raw, qual, new_faults, latch_q, latch_d, lamp_q, lamp_d;
  logic          new_fault, ack_rise, rst_rise, rst_accept;
  logic          ack_prev_q, rst_prev_q;
  logic [1:0]    first_idx, first_out_q;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  logic          trip_q, horn_q, first_valid_q;
  logic [7:0]    count_q;

  assign raw = {~i_u_ca_low_n, ~i_i_ca_high_n, i_not_ca_ok & i_ca_delay, ~i_not_alarm};

  // Qualification fires on the same edge the counter reaches QUAL.
  for (genvar i = 0; i < 4; i++) begin : g_qual
    logic [3:0] cnt_q, cnt_d;
    always_comb begin
      cnt_d = 4'd0;
      if (raw[i]) cnt_d = (cnt_q == QUAL_C) ? QUAL_C : cnt_q + 4'd1;
    end
    assign qual[i] = (cnt_d == QUAL_C);
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= 4'd0;
      else        cnt_q <= cnt_d;
    end
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q + BW'(1);
    blink_d     = blink_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
  end

  always_comb begin
    new_faults = qual & ~latch_q;
    new_fault  = |new_faults;
    ack_rise   = i_ack & ~ack_prev_q;
    rst_rise   = i_rst & ~rst_prev_q;
    rst_accept = (state_q == ACKED) && !new_fault && rst_rise && (qual == 4'd0);
    first_idx  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (new_faults[i]) first_idx = 2'(i);
    end
    latch_d = rst_accept ? 4'd0 : (latch_q | qual);
    state_d = state_q;
    case (state_q)
      NORMAL:  if (new_fault) state_d = TRIP;
      TRIP:    if (!new_fault && ack_rise) state_d = ACKED;
      ACKED: begin
        if (new_fault)       state_d = TRIP;
        else if (rst_accept) state_d = NORMAL;
      end
      default: state_d = NORMAL;
    endcase
    lamp_d = 4'd0;
    if (state_d == TRIP)       lamp_d = latch_d & {4{blink_d}};
    else if (state_d == ACKED) lamp_d = latch_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      latch_q     <= 4'd0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
      ack_prev_q  <= 1'b0;
      rst_prev_q  <= 1'b0;
    end else begin
      latch_q     <= latch_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      ack_prev_q  <= i_ack;
      rst_prev_q  <= i_rst;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= NORMAL;
      trip_q        <= 1'b0;
      horn_q        <= 1'b0;
      lamp_q        <= 4'd0;
      first_out_q   <= 2'd0;
      first_valid_q <= 1'b0;
      count_q       <= 8'd0;
    end else begin
      state_q <= state_d;
      trip_q  <= (state_d != NORMAL);
      horn_q  <= (state_d == TRIP);
      lamp_q  <= lamp_d;
      // Only the NORMAL->TRIP transition records first-out and counts a trip.
      if (state_q == NORMAL && new_fault) begin
        first_out_q   <= first_idx;
        first_valid_q <= 1'b1;
        if (count_q != 8'hFF) count_q <= count_q + 8'd1;
      end else if (rst_accept) begin
        first_out_q   <= 2'd0;
        first_valid_q <= 1'b0;
      end
    end
  end

  assign o_trip        = trip_q;
  assign o_horn        = horn_q;
  assign o_lamp        = lamp_q;
  assign o_first_out   = first_out_q;
  assign o_first_valid = first_valid_q;
  assign o_trip_count  = count_q;

endmodule
`default_nettype wire
